// File: rtl/bp_stall_profile_counters_if.sv
// Read port between the stall profiler counters and the shell's CSR logic.
interface bp_stall_profile_counters_if #(
  parameter int cnt_width_p = 32
);
  logic                   rd_v_i;
  logic [4:0]             rd_addr_i;
  logic                   rd_ready_o;
  logic                   rd_v_o;
  logic [cnt_width_p-1:0] rd_data_o;
  logic                   rd_yumi_i;

  modport master (
    output rd_v_i, rd_addr_i, rd_yumi_i,
    input  rd_ready_o, rd_v_o, rd_data_o
  );

  modport slave (
    input  rd_v_i, rd_addr_i, rd_yumi_i,
    output rd_ready_o, rd_v_o, rd_data_o
  );
endinterface

// File: rtl/bp_stall_profile_counters.sv
// Per-reason stall histogram with saturating counters and a valid/ready read port.
// Optional shadow bank for coherent snapshots: define BP_STALL_PROF_SNAPSHOT_EN.
module bp_stall_profile_counters #(
  parameter int cnt_width_p   = 32,
  parameter int num_reasons_p = 30
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       en_i,
  input  logic       commit_v_i,
  input  logic       stall_v_i,
  input  logic [5:0] stall_reason_i,
  input  logic       clear_i,
  input  logic       snapshot_i,
  output logic       bad_reason_o,
  output logic       sat_o,
  bp_stall_profile_counters_if.slave rd
);

  localparam int num_cnt_lp   = 32;
  localparam int total_idx_lp = 30;
  localparam int commit_idx_lp = 31;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [cnt_width_p-1:0] cnt_q [num_cnt_lp];
  logic [cnt_width_p-1:0] cnt_n [num_cnt_lp];
  logic [num_cnt_lp-1:0]  inc;
  logic                   bad_event;
  logic                   sat_event;
  logic [cnt_width_p-1:0] rd_src;
  logic [cnt_width_p-1:0] data_q;
  logic [0:0]             state_q;

  // Illegal reason codes are folded into the unknown bucket.
  always_comb begin
    inc       = '0;
    bad_event = 1'b0;
    if (en_i) begin
      inc[total_idx_lp] = 1'b1;
      if (commit_v_i) inc[commit_idx_lp] = 1'b1;
      if (stall_v_i) begin
        if (stall_reason_i < 6'(num_reasons_p)) begin
          inc[stall_reason_i[4:0]] = 1'b1;
        end else begin
          inc[0]    = 1'b1;
          bad_event = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sat_event = 1'b0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      cnt_n[i] = cnt_q[i];
      if (inc[i]) begin
        if (&cnt_q[i]) sat_event = 1'b1;
        else           cnt_n[i] = cnt_q[i] + cnt_width_p'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || clear_i) begin
      for (int i = 0; i < num_cnt_lp; i++) cnt_q[i] <= '0;
      bad_reason_o <= 1'b0;
      sat_o        <= 1'b0;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) cnt_q[i] <= cnt_n[i];
      bad_reason_o <= bad_reason_o | bad_event;
      sat_o        <= sat_o | sat_event;
    end
  end

`ifdef BP_STALL_PROF_SNAPSHOT_EN
  logic [cnt_width_p-1:0] shadow_q [num_cnt_lp];

  // The snapshot captures the post-increment values so the same-cycle event is included.
  always_ff @(posedge aclk) begin
    if (!aresetn || clear_i) begin
      for (int i = 0; i < num_cnt_lp; i++) shadow_q[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < num_cnt_lp; i++) shadow_q[i] <= cnt_n[i];
    end
  end

  assign rd_src = shadow_q[rd.rd_addr_i];
`else
  logic unused_snapshot;
  assign unused_snapshot = snapshot_i;
  assign rd_src = cnt_q[rd.rd_addr_i];
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd.rd_v_i) begin
            data_q  <= rd_src;
            state_q <= RESP;
          end
        end
        default: begin
          if (rd.rd_yumi_i) state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is held low throughout reset even though the state register already reads IDLE.
  assign rd.rd_ready_o = aresetn && (state_q == IDLE);
  assign rd.rd_v_o     = (state_q == RESP);
  assign rd.rd_data_o  = data_q;

endmodule

// File: tb/tb_bp_stall_profile_counters.sv
// Directed bench for bp_stall_profile_counters: a 32-bit and a 4-bit instance share stimulus.
module tb_bp_stall_profile_counters;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       en_i, commit_v_i, stall_v_i, clear_i, snapshot_i;
  logic [5:0] stall_reason_i;
  logic       rd_v_i, rd_yumi_i;
  logic [4:0] rd_addr_i;
  logic       bad_w, sat_w, bad_n, sat_n;

  int compared   = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  bp_stall_profile_counters_if #(.cnt_width_p(32)) rd_w ();
  bp_stall_profile_counters_if #(.cnt_width_p(4))  rd_n ();

  assign rd_w.rd_v_i    = rd_v_i;
  assign rd_w.rd_addr_i = rd_addr_i;
  assign rd_w.rd_yumi_i = rd_yumi_i;
  assign rd_n.rd_v_i    = rd_v_i;
  assign rd_n.rd_addr_i = rd_addr_i;
  assign rd_n.rd_yumi_i = rd_yumi_i;

  bp_stall_profile_counters #(.cnt_width_p(32), .num_reasons_p(30)) dut_w (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .commit_v_i(commit_v_i),
    .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i), .clear_i(clear_i),
    .snapshot_i(snapshot_i), .bad_reason_o(bad_w), .sat_o(sat_w), .rd(rd_w)
  );

  bp_stall_profile_counters #(.cnt_width_p(4), .num_reasons_p(30)) dut_n (
    .aclk(aclk), .aresetn(aresetn), .en_i(en_i), .commit_v_i(commit_v_i),
    .stall_v_i(stall_v_i), .stall_reason_i(stall_reason_i), .clear_i(clear_i),
    .snapshot_i(snapshot_i), .bad_reason_o(bad_n), .sat_o(sat_n), .rd(rd_n)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input bit commit, input bit stall,
                               input logic [5:0] reason, input bit clr, input bit snap);
    en_i = en; commit_v_i = commit; stall_v_i = stall;
    stall_reason_i = reason; clear_i = clr; snapshot_i = snap;
    step();
    en_i = 0; commit_v_i = 0; stall_v_i = 0;
    stall_reason_i = '0; clear_i = 0; snapshot_i = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rd_w.rd_ready_o && n < 10) begin
      step();
      n++;
    end
    if (!rd_w.rd_ready_o) checkOutput("rd_ready_timeout", 32'(rd_w.rd_ready_o), 32'd1);
  endtask

  task automatic do_read(input logic [4:0] addr, input bit snap,
                         output logic [31:0] dw, output logic [3:0] dn);
    if (snap) applyStimulus(0, 0, 0, 6'd0, 0, 1);
    wait_ready();
    rd_v_i = 1; rd_addr_i = addr;
    step();
    rd_v_i = 0;
    checkOutput("rd_v_after_accept", 32'(rd_w.rd_v_o), 32'd1);
    dw = rd_w.rd_data_o;
    dn = rd_n.rd_data_o;
    rd_yumi_i = 1;
    step();
    rd_yumi_i = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] dw;
    logic [3:0]  dn;

    aresetn = 0; rd_v_i = 0; rd_yumi_i = 0; rd_addr_i = '0;
    en_i = 0; commit_v_i = 0; stall_v_i = 0; stall_reason_i = '0;
    clear_i = 0; snapshot_i = 0;
    repeat (3) step();
    checkOutput("ready_in_reset", 32'(rd_w.rd_ready_o), 32'd0);
    checkOutput("rd_v_in_reset", 32'(rd_w.rd_v_o), 32'd0);
    checkOutput("data_in_reset", rd_w.rd_data_o, 32'd0);
    checkOutput("bad_in_reset", 32'(bad_w), 32'd0);
    checkOutput("sat_in_reset", 32'(sat_w), 32'd0);
    aresetn = 1;
    step();
    checkOutput("ready_after_reset", 32'(rd_w.rd_ready_o), 32'd1);
    do_read(5'd30, 1, dw, dn); checkOutput("reset_total", dw, 32'd0);

    $display("[TB] ten enabled cycles, four dc_miss stalls");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, (i < 8) && (i % 2 == 1), 6'd2, 0, 0);
    do_read(5'd2,  1, dw, dn); checkOutput("dc_miss_count", dw, 32'd4);
    do_read(5'd30, 1, dw, dn); checkOutput("total_10", dw, 32'd10);
    do_read(5'd31, 1, dw, dn); checkOutput("commits_0", dw, 32'd0);

    $display("[TB] illegal reason 45");
    applyStimulus(1, 0, 1, 6'd45, 0, 0);
    checkOutput("bad_set", 32'(bad_w), 32'd1);
    do_read(5'd0,  1, dw, dn); checkOutput("unknown_1", dw, 32'd1);
    do_read(5'd30, 1, dw, dn); checkOutput("total_11", dw, 32'd11);
    applyStimulus(0, 0, 0, 6'd0, 1, 0);
    checkOutput("bad_cleared", 32'(bad_w), 32'd0);
    do_read(5'd0,  1, dw, dn); checkOutput("unknown_cleared", dw, 32'd0);
    do_read(5'd30, 1, dw, dn); checkOutput("total_cleared", dw, 32'd0);

    $display("[TB] saturation on the 4-bit instance");
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1, 6'd29, 0, 0);
    do_read(5'd29, 1, dw, dn);
    checkOutput("ic_miss_sat_n", 32'(dn), 32'd15);
    checkOutput("ic_miss_wide", dw, 32'd20);
    checkOutput("sat_n_set", 32'(sat_n), 32'd1);
    checkOutput("sat_w_clear", 32'(sat_w), 32'd0);
    do_read(5'd30, 1, dw, dn); checkOutput("total_sat_n", 32'(dn), 32'd15);
    applyStimulus(0, 0, 0, 6'd0, 1, 0);
    checkOutput("sat_n_cleared", 32'(sat_n), 32'd0);

    $display("[TB] clear wins; commit and stall together");
    applyStimulus(1, 0, 1, 6'd5, 1, 0);
    do_read(5'd5,  1, dw, dn); checkOutput("clear_wins_r5", dw, 32'd0);
    do_read(5'd30, 1, dw, dn); checkOutput("clear_wins_total", dw, 32'd0);
    applyStimulus(1, 1, 1, 6'd7, 0, 0);
    do_read(5'd31, 1, dw, dn); checkOutput("commit_both", dw, 32'd1);
    do_read(5'd7,  1, dw, dn); checkOutput("r7_both", dw, 32'd1);
    do_read(5'd30, 1, dw, dn); checkOutput("total_both", dw, 32'd1);

    $display("[TB] read returns pre-increment value");
    applyStimulus(0, 0, 0, 6'd0, 0, 1);
    wait_ready();
    rd_v_i = 1; rd_addr_i = 5'd7; en_i = 1; stall_v_i = 1; stall_reason_i = 6'd7;
    step();
    rd_v_i = 0; en_i = 0; stall_v_i = 0; stall_reason_i = '0;
    checkOutput("pre_inc_r7", rd_w.rd_data_o, 32'd1);
    rd_yumi_i = 1; step(); rd_yumi_i = 0;
    do_read(5'd7, 1, dw, dn); checkOutput("post_inc_r7", dw, 32'd2);

    $display("[TB] response held while yumi is low");
    applyStimulus(0, 0, 0, 6'd0, 0, 1);
    wait_ready();
    rd_v_i = 1; rd_addr_i = 5'd31;
    step();
    rd_v_i = 0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_data", rd_w.rd_data_o, 32'd1);
      checkOutput("hold_ready", 32'(rd_w.rd_ready_o), 32'd0);
      checkOutput("hold_valid", 32'(rd_w.rd_v_o), 32'd1);
      applyStimulus(i == 0, i == 0, 0, 6'd0, i == 2, i == 1);
    end
    checkOutput("hold_data_end", rd_w.rd_data_o, 32'd1);
    rd_yumi_i = 1; step(); rd_yumi_i = 0;
    checkOutput("released_valid", 32'(rd_w.rd_v_o), 32'd0);
    checkOutput("released_ready", 32'(rd_w.rd_ready_o), 32'd1);
    do_read(5'd31, 1, dw, dn); checkOutput("commits_after_clear", dw, 32'd0);

    $display("[TB] reset during response");
    applyStimulus(1, 1, 0, 6'd0, 0, 1);
    wait_ready();
    rd_v_i = 1; rd_addr_i = 5'd31;
    step();
    rd_v_i = 0;
    checkOutput("resp_before_reset", rd_w.rd_data_o, 32'd1);
    aresetn = 0;
    step();
    checkOutput("rd_v_aborted", 32'(rd_w.rd_v_o), 32'd0);
    checkOutput("ready_low_reset", 32'(rd_w.rd_ready_o), 32'd0);
    aresetn = 1;
    step();
    checkOutput("ready_after_abort", 32'(rd_w.rd_ready_o), 32'd1);
    do_read(5'd31, 1, dw, dn); checkOutput("commits_after_reset", dw, 32'd0);

    $display("[TB] snapshot at six of reason 3, five more after");
    for (int i = 0; i < 11; i++) applyStimulus(1, 0, 1, 6'd3, 0, i == 5);
    do_read(5'd3, 0, dw, dn);
`ifdef BP_STALL_PROF_SNAPSHOT_EN
    checkOutput("snapshot_r3", dw, 32'd6);
`else
    checkOutput("snapshot_r3", dw, 32'd11);
`endif
    do_read(5'd3, 1, dw, dn); checkOutput("live_r3", dw, 32'd11);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bp_stall_profile_counters.md
# bp_stall_profile_counters

Per-reason stall histogram for the BlackParrot profiler. Consumes the per-cycle encoded stall-reason stream from the core-side profiler, which uses the 6-bit `bp_stall_reason_e` encoding: 0 = unknown through 29 = ic_miss. Maintains one saturating counter per reason plus total-cycle and commit counters. Exposes all 32 counters through a valid/ready read port to the shell's CSR logic.

## Interface
Parameters:
- `cnt_width_p`, 32: width of every counter and of `rd_data_o`.
- `num_reasons_p`, 30: number of legal reason codes, 0..29; fixed by `bp_stall_reason_e`.

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: synchronous active-low reset.
- `en_i`, in, 1: counting enable. When low, no counter changes except by `clear_i`.
- `commit_v_i`, in, 1: an instruction retired this cycle.
- `stall_v_i`, in, 1: this cycle is attributed to a stall reason.
- `stall_reason_i`, in, 6: `bp_stall_reason_e` code; sampled only when `stall_v_i`.
- `clear_i`, in, 1: pulse that zeroes all counters and sticky flags.
- `snapshot_i`, in, 1: copy live counters into the shadow bank (see Configuration).
- `rd_v_i`, in, 1: read request valid.
- `rd_addr_i`, in, 5: counter index. 0..29 = reason counters; 30 = total enabled cycles; 31 = commits.
- `rd_ready_o`, out, 1: read request can be accepted.
- `rd_v_o`, out, 1: read response valid.
- `rd_data_o`, out, `cnt_width_p`: read response data.
- `rd_yumi_i`, in, 1: consumer takes the response. Legal only while `rd_v_o`.
- `bad_reason_o`, out, 1: sticky flag; an illegal reason code was seen.
- `sat_o`, out, 1: sticky flag; some counter saturated.

## Operation
- Counter updates, each evaluated every cycle with `en_i`=1:
  - counter[30] += 1 every cycle.
  - counter[31] += 1 if `commit_v_i`.
  - counter[`stall_reason_i`] += 1 if `stall_v_i`.
  - `commit_v_i` and `stall_v_i` together in one cycle: both counters increment.
- Illegal reason code (30..63) with `stall_v_i`: counter[0] (unknown) increments instead, and `bad_reason_o` sets.
- Saturation: a counter at all-ones holds its value. `sat_o` sets when any increment is suppressed.
- `clear_i`: on the next edge, all live counters, the shadow bank, `bad_reason_o` and `sat_o` go to 0. Clear wins over any same-cycle increment; that event is dropped.
- Read FSM has two states:
  - IDLE: `rd_ready_o`=1. On `rd_v_i`, latch the selected counter value as of the start of the accept cycle (pre-increment) into `rd_data_o`, then go to RESP.
  - RESP: `rd_v_o`=1 and `rd_ready_o`=0. `rd_data_o` holds stable. On `rd_yumi_i`, return to IDLE.
- A response already latched is unaffected by `clear_i`, `snapshot_i` or later increments.
- Reset values:
  - All counters, shadow bank, `rd_data_o`, `rd_v_o`, `bad_reason_o` and `sat_o` are 0.
  - FSM is in IDLE.
  - `rd_ready_o` is 0 while `aresetn`=0 and 1 from the first cycle after reset is released.
- Reset asserted mid-transaction aborts the response; `rd_v_o` is 0 on the next cycle.

## Timing
- Increment latency: an event in cycle N is visible to a read accepted in cycle N+1.
- Read latency: request accepted in cycle N gives `rd_v_o`=1 in cycle N+1. With yumi in cycle N+1, the earliest next accept is cycle N+2, so peak throughput is one read per 2 cycles.
- `rd_ready_o` and `rd_v_o` are registered-state-only outputs, with no combinational path from `rd_v_i` or `rd_yumi_i`.
- Sticky flags set on the edge after the causing event.

## Configuration
- `BP_STALL_PROF_SNAPSHOT_EN` defined:
  - A 32-entry shadow bank exists.
  - `snapshot_i` copies all live counters, including any increment from that same cycle, into it on the next edge.
  - Reads return shadow values. Live counters keep running.
  - `clear_i` together with `snapshot_i`: the shadow bank becomes 0.
- `BP_STALL_PROF_SNAPSHOT_EN` undefined: no shadow bank; `snapshot_i` is ignored; reads return live counters.

## Test plan
- Reset, then `en_i`=1 for 10 cycles with `stall_v_i`=1 and reason 2 (dc_miss) on 4 of them. Read addr 2 → 4; read addr 30 → 10.
- Reason 45 with `stall_v_i` for 1 cycle → counter[0] becomes 1 and `bad_reason_o`=1. Then `clear_i` → `bad_reason_o`=0 and counter[0] reads 0.
- `cnt_width_p`=4: 20 cycles of reason 29 → addr 29 reads 15 and `sat_o`=1.
- `clear_i` in the same cycle as reason 5 → addr 5 reads 0. Same cycle `commit_v_i` and `stall_v_i` with reason 7 → addr 31 and addr 7 each increment by 1.
- Read handshake:
  - Accept addr 31 and hold `rd_yumi_i`=0 for 3 cycles → `rd_data_o` stable, `rd_ready_o`=0.
  - Assert `aresetn`=0 mid-RESP → `rd_v_o`=0 next cycle.
- With `BP_STALL_PROF_SNAPSHOT_EN`: snapshot at count 6 of reason 3, then 5 more events → read addr 3 returns 6. Without the macro, the same sequence returns 11.
